conv3x3_stream_core: RTL and testbench

- Single-channel streaming 3x3 convolution core for the CNN datapath: row-major 8-bit pixels in, one 32-bit signed accumulation per valid window out.
- Integrates three functions in one block: a two-row line buffer, a 3x3 sliding-window register array, and a pipelined 9-tap multiply-accumulate.
- Downstream layer logic (quantization, ReLU, saturation) consumes out_mac; that logic is not part of this block.

---
 rtl/conv3x3_stream_core.sv | 121 ++++++++++++
 tb/tb_conv3x3_stream_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_core.sv
// Streaming 3x3 convolution core.
// A two-row line buffer feeds a 3x3 sliding window. A two-stage multiply-accumulate
// produces one signed 32-bit sum for each complete window.
module conv3x3_stream_core #(
    parameter int unsigned IMG_W           = 28,
    parameter int unsigned IMG_H           = 28,
    parameter bit          INPUT_IS_SIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic [71:0] weights,
    output logic        out_valid,
    output logic [31:0] out_mac
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               col_last;
    logic               row_last;

    logic [7:0]         lb1 [IMG_W];   // row r-1
    logic [7:0]         lb0 [IMG_W];   // row r-2

    logic [7:0]         win [9];       // tap k = 3*wr + wc
    logic               win_valid;

    logic signed [8:0]  pix_ext [9];
    logic signed [16:0] prod [9];
    logic               prod_valid;
    logic signed [31:0] sum;

    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));

    // Raster position of the next accepted pixel; wraps per row and per frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffer: push the previous row down one line and store the new pixel
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0[col] <= lb1[col];
            lb1[col] <= in_data;
        end
    end

    // Window shift on accept. Valid only when the full 3x3 window lies within the current frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 9; i++) win[i] <= '0;
            win_valid <= 1'b0;
        end else if (in_valid) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win[3*r]     <= win[3*r + 1];
                win[3*r + 1] <= win[3*r + 2];
            end
            win[2]    <= lb0[col];
            win[5]    <= lb1[col];
            win[8]    <= in_data;
            win_valid <= (row >= RW'(2)) && (col >= CW'(2));
        end else begin
            win_valid <= 1'b0;
        end
    end

    // Extend each pixel to 9 bits signed, using the input signedness
    always_comb begin
        for (int unsigned i = 0; i < 9; i++) begin
            pix_ext[i] = {INPUT_IS_SIGNED & win[i][7], win[i]};
        end
    end

    // Product stage. The weights are sampled here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 9; i++) prod[i] <= '0;
            prod_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 9; i++) begin
                prod[i] <= pix_ext[i] * $signed(weights[8*i +: 8]);
            end
            prod_valid <= win_valid;
        end
    end

    // Sum the nine sign-extended products at full precision
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            sum = sum + $signed({{15{prod[i][16]}}, prod[i]});
        end
    end

    // Output stage. The result holds between valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mac   <= '0;
        end else begin
            out_valid <= prod_valid;
            if (prod_valid) out_mac <= sum;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_core.sv
// Bench for conv3x3_stream_core on a 4x4 image.
// One DUT takes unsigned pixels and one takes signed pixels. Both receive the same stream.
// A frame-array reference model predicts every output and the cycle it should appear in.
module tb_conv3x3_stream_core;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [71:0] weights;
    logic        ova, ovb;
    logic [31:0] maca, macb;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t         qa[$], qb[$];
    int           cap_a[$], cap_b[$];
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    byte unsigned img[H][W];
    int           pcount;
    int           w[9];
    int           last_a, last_b;

    conv3x3_stream_core #(.IMG_W(W), .IMG_H(H), .INPUT_IS_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .weights(weights), .out_valid(ova), .out_mac(maca)
    );

    conv3x3_stream_core #(.IMG_W(W), .IMG_H(H), .INPUT_IS_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .weights(weights), .out_valid(ovb), .out_mac(macb)
    );

    always #5 clk = ~clk;

    // Count rising edges so the model can schedule expected results
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
                     tag, $signed(got), got, $signed(exp), exp, cyc);
        end
    endtask

    function automatic int ext(byte unsigned p, bit s);
        return s ? int'($signed(p)) : int'(p);
    endfunction

    // Reference convolution taken directly from the stored frame
    function automatic int win_sum(int r, int c, bit s);
        int acc = 0;
        for (int wr = 0; wr < 3; wr++)
            for (int wc = 0; wc < 3; wc++)
                acc += ext(img[r-2+wr][c-2+wc], s) * w[3*wr + wc];
        return acc;
    endfunction

    task automatic apply_weights();
        for (int k = 0; k < 9; k++) weights[8*k +: 8] = 8'(w[k]);
    endtask

    task automatic set_all_weights(int v);
        for (int k = 0; k < 9; k++) w[k] = v;
        apply_weights();
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #2;
            in_valid = 1'b0;
        end
    endtask

    // Present one pixel after `gap` idle cycles. The following rising edge accepts it.
    task automatic send(byte unsigned p, int gap);
        int r, c;
        repeat (gap) begin
            @(posedge clk); #2;
            in_valid = 1'b0;
        end
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_data  = p;
        r = (pcount / W) % H;
        c = pcount % W;
        img[r][c] = p;
        if (r >= 2 && c >= 2) begin
            qa.push_back('{cyc + 3, win_sum(r, c, 1'b0)});
            qb.push_back('{cyc + 3, win_sum(r, c, 1'b1)});
        end
        pcount++;
    endtask

    task automatic ramp_frame(int maxgap);
        for (int p = 0; p < W*H; p++)
            send(8'(p), (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
    endtask

    task automatic const_frame(byte unsigned v);
        for (int p = 0; p < W*H; p++) send(v, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst = 1'b1;
        qa.delete(); qb.delete();
        last_a = 0; last_b = 0;
        pcount = 0;
        #1;
        check_eq("rst_valid_u", 32'(ova), 0);
        check_eq("rst_mac_u", maca, 0);
        check_eq("rst_valid_s", 32'(ovb), 0);
        check_eq("rst_mac_s", macb, 0);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic expect_caps(string tag, bit use_s, int e[$]);
        int got[$];
        got = use_s ? cap_b : cap_a;
        check_eq({tag, "_count"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++)
            check_eq(tag, got[i], e[i]);
    endtask

    // Per-cycle checks of out_valid timing and of out_mac (updated or held)
    always @(negedge clk) begin : monitor
        exp_t e;
        logic ev;
        while (qa.size() > 0 && qa[0].due < cyc) void'(qa.pop_front());
        while (qb.size() > 0 && qb[0].due < cyc) void'(qb.pop_front());
        ev = (qa.size() > 0) && (qa[0].due == cyc);
        if (ev) begin e = qa.pop_front(); last_a = e.val; end
        check_eq("valid_u", 32'(ova), 32'(ev));
        check_eq("mac_u", maca, last_a);
        ev = (qb.size() > 0) && (qb[0].due == cyc);
        if (ev) begin e = qb.pop_front(); last_b = e.val; end
        check_eq("valid_s", 32'(ovb), 32'(ev));
        check_eq("mac_s", macb, last_b);
        if (ova) cap_a.push_back(int'(maca));
        if (ovb) cap_b.push_back(int'(macb));
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int e[$];
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        last_a = 0; last_b = 0; pcount = 0;
        set_all_weights(1);
        do_reset();

        // Ramp with all weights = 1
        cap_a.delete();
        ramp_frame(0); idle(5);
        e = '{45, 54, 81, 90};
        expect_caps("ramp", 1'b0, e);

        // Only the centre tap set
        set_all_weights(0); w[4] = 1; apply_weights();
        cap_a.delete();
        ramp_frame(0); idle(5);
        e = '{5, 6, 9, 10};
        expect_caps("centre", 1'b0, e);

        // Ramp with 1-3 idle cycles between pixels
        set_all_weights(1);
        cap_a.delete();
        ramp_frame(3); idle(5);
        e = '{45, 54, 81, 90};
        expect_caps("stall", 1'b0, e);

        // Extreme values
        set_all_weights(-128);
        cap_a.delete();
        const_frame(8'hFF); idle(5);
        e = '{-293760, -293760, -293760, -293760};
        expect_caps("ext_u", 1'b0, e);
        cap_b.delete();
        const_frame(8'h80); idle(5);
        e = '{147456, 147456, 147456, 147456};
        expect_caps("ext_s", 1'b1, e);

        // Reset in the middle of a frame, then a full frame
        set_all_weights(1);
        for (int p = 0; p < 6; p++) send(8'(p), 0);
        do_reset();
        cap_a.delete();
        ramp_frame(0); idle(5);
        e = '{45, 54, 81, 90};
        expect_caps("midrst", 1'b0, e);

        // Two frames back to back
        cap_a.delete();
        ramp_frame(0); ramp_frame(0); idle(5);
        e = '{45, 54, 81, 90, 45, 54, 81, 90};
        expect_caps("b2b", 1'b0, e);

        // Random weights, pixels and gaps; checked only against the model
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 9; k++) w[k] = int'($signed(8'($urandom)));
            apply_weights();
            for (int p = 0; p < W*H; p++)
                send(8'($urandom), int'($urandom_range(0, 2)));
            idle(5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
